norm_pass_sequencer: RTL and testbench
======================================

# norm_pass_sequencer

Job controller for the descriptor L2-normalize datapath. It reads a batch of vectors from memory and drives the DataMover command and status channels. Each vector is streamed into the normalizer twice (pass 1 computes the sum of squares, pass 2 scales) and the normalized result is written back once. It sits between the CPU register file and the MM2S/S2MM DataMover pair that feeds and drains the normalizer.

## Interface
- ADDR_W, 32, byte-address width
- BTT_W, 23, DataMover bytes-to-transfer width
- CNT_W, 16, vector-count width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job-launch pulse; sampled only in IDLE
- src_addr  in  ADDR_W  byte address of vector 0 input
- dst_addr  in  ADDR_W  byte address of vector 0 output
- stride  in  ADDR_W  byte step between consecutive vectors (source and destination)
- vec_bytes  in  BTT_W  bytes per vector; a multiple of 8, nonzero
- num_vec  in  CNT_W  vectors in the job
- busy  out  1  high from accepted start until done or error
- done  out  1  one-cycle pulse at job completion
- error  out  1  sticky; cleared by the next accepted start
- vec_cnt  out  CNT_W  vectors completed in the current job
- mm2s_cmd_valid / mm2s_cmd_ready  out / in  1  read-command handshake
- mm2s_cmd_addr  out  ADDR_W; mm2s_cmd_btt  out  BTT_W
- s2mm_cmd_valid / s2mm_cmd_ready  out / in  1  write-command handshake
- s2mm_cmd_addr  out  ADDR_W; s2mm_cmd_btt  out  BTT_W
- in_beat_last  in  1  normalizer input tvalid&tready&tlast
- s2mm_sts_valid  in  1  write-status strobe; s2mm_sts_okay  in  1  status result
- s2mm_sts_ready  out  1  asserted in WR_WAIT only

## Operation
- States: IDLE, RD1_CMD, RD1_WAIT, WR_CMD, RD2_CMD, RD2_WAIT, WR_WAIT, ERR.
- IDLE, start=1:
  - Latch all job fields; clear error and vec_cnt; set busy.
  - num_vec=0 → done pulse, stay IDLE.
  - vec_bytes=0 or vec_bytes[2:0]≠0 → ERR.
  - Otherwise → RD1_CMD.
- RD1_CMD: mm2s_cmd = {cur_src, vec_bytes}. On handshake → RD1_WAIT.
- RD1_WAIT: wait for in_beat_last → WR_CMD. This ends pass 1.
- WR_CMD: s2mm_cmd = {cur_dst, vec_bytes}. On handshake → RD2_CMD. The write is always armed before pass-2 data exists.
- RD2_CMD: mm2s_cmd = {cur_src, vec_bytes}, the same address as pass 1. On handshake → RD2_WAIT.
- RD2_WAIT: wait for in_beat_last → WR_WAIT.
- WR_WAIT: on s2mm_sts_valid:
  - okay=1: vec_cnt+1; cur_src += stride; cur_dst += stride. Last vector → done, IDLE; else → RD1_CMD.
  - okay=0 → ERR.
- ERR: set error, clear busy, → IDLE. No further commands are issued.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- in_beat_last outside RD1_WAIT/RD2_WAIT is ignored.
- start while busy is ignored.

## Timing
- Reset values: busy=0, done=0, error=0, vec_cnt=0, both cmd_valid=0, s2mm_sts_ready=0, state IDLE.
- All outputs are registered.
- start at cycle T → busy=1 and mm2s_cmd_valid=1 at T+1.
- cmd_valid is held with stable addr/btt until ready. It deasserts the cycle after the handshake, so there is one command per handshake.
- in_beat_last in RD1_WAIT at cycle T → s2mm_cmd_valid=1 at T+1.
- Status accepted at cycle T:
  - Next mm2s_cmd_valid at T+1.
  - On the last vector, done=1 and busy=0 at T+1, and vec_cnt=num_vec at T+1.
- Per-vector overhead beyond the data streams: 4 command cycles plus the handshake waits.
- Reset mid-job: immediate return to IDLE with all valids low. The normalizer and DataMover share rst and are flushed together; partial vectors are not resumed.

## Structure
- The shared package holds the state enum, ADDR_W/BTT_W/CNT_W defaults, and the DataMover command struct {addr, btt}.
- One sub-module, norm_addr_gen: holds cur_src/cur_dst with load (start) and advance (status okay) controls.
- The FSM stays in the top.

## Test plan
- **Normal job.** num_vec=3, vec_bytes=512, src=0x1000, dst=0x8000, stride=0x200 → expected:
  - MM2S addrs 0x1000,0x1000,0x1200,0x1200,0x1400,0x1400.
  - S2MM addrs 0x8000,0x8200,0x8400.
  - done once, vec_cnt=3.
- **Backpressure.** mm2s_cmd_ready low for 5 cycles → valid, addr and btt stable throughout; exactly one command counted.
- **Ordering.** Per vector: RD1 handshake, pass-1 last, S2MM handshake, RD2 handshake. No S2MM command before pass-1 last.
- **Illegal jobs.**
  - num_vec=0 → done at T+1, no commands.
  - vec_bytes=12 → error=1, busy=0, no commands.
- **Status error.** s2mm_sts_okay=0 on vector 2 of 4 → error=1, vec_cnt=1, no more commands. The next start clears error.
- **Reset and address wrap.**
  - rst asserted in RD2_WAIT → next cycle all outputs at reset values.
  - src=0xFFFF_FF00, stride=0x200 → second vector address 0x0000_0100.

Source files
------------

// File: rtl/norm_pass_sequencer_pkg.sv
// Shared definitions for the L2-normalize job sequencer: state codes,
// default widths and the DataMover command record.
package norm_pass_sequencer_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_BTT_W  = 23;
  localparam int DEF_CNT_W  = 16;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD1_CMD  = 3'd1;
  localparam logic [2:0] S_RD1_WAIT = 3'd2;
  localparam logic [2:0] S_WR_CMD   = 3'd3;
  localparam logic [2:0] S_RD2_CMD  = 3'd4;
  localparam logic [2:0] S_RD2_WAIT = 3'd5;
  localparam logic [2:0] S_WR_WAIT  = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  // DataMover command: start address plus bytes-to-transfer
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_BTT_W-1:0]  btt;
  } dm_cmd_t;

endpackage

// File: rtl/norm_pass_sequencer_addr_gen.sv
// Current source/destination vector pointers. Loaded at job start,
// stepped by the shared stride after each successfully written vector.
module norm_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] cur_src,
  output logic [ADDR_W-1:0] cur_dst
);

  logic [ADDR_W-1:0] stride_q;

  // Pointer registers; wrap past 2^ADDR_W is intentional and silent
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_src  <= '0;
      cur_dst  <= '0;
      stride_q <= '0;
    end else if (load) begin
      cur_src  <= src;
      cur_dst  <= dst;
      stride_q <= stride;
    end else if (advance) begin
      cur_src  <= cur_src + stride_q;
      cur_dst  <= cur_dst + stride_q;
    end
  end

endmodule

// File: rtl/norm_pass_sequencer.sv
// Job controller for the L2-normalize datapath: each vector is read twice
// (sum of squares, then scale) and written back once. The write command is
// armed between the two reads so S2MM is ready before pass-2 data appears.
module norm_pass_sequencer
  import norm_pass_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BTT_W  = DEF_BTT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [BTT_W-1:0]  vec_bytes,
  input  logic [CNT_W-1:0]  num_vec,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic              mm2s_cmd_valid,
  input  logic              mm2s_cmd_ready,
  output logic [ADDR_W-1:0] mm2s_cmd_addr,
  output logic [BTT_W-1:0]  mm2s_cmd_btt,
  output logic              s2mm_cmd_valid,
  input  logic              s2mm_cmd_ready,
  output logic [ADDR_W-1:0] s2mm_cmd_addr,
  output logic [BTT_W-1:0]  s2mm_cmd_btt,
  input  logic              in_beat_last,
  input  logic              s2mm_sts_valid,
  input  logic              s2mm_sts_okay,
  output logic              s2mm_sts_ready
);

  state_t           state;
  logic [BTT_W-1:0] btt_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load, advance, mm2s_hs, s2mm_hs;

  assign load    = (state == S_IDLE) && start;
  assign advance = (state == S_WR_WAIT) && s2mm_sts_valid && s2mm_sts_okay;
  assign mm2s_hs = mm2s_cmd_valid && mm2s_cmd_ready;
  assign s2mm_hs = s2mm_cmd_valid && s2mm_cmd_ready;
  assign cnt_nxt = vec_cnt + 1'b1;

  assign mm2s_cmd_btt = btt_q;
  assign s2mm_cmd_btt = btt_q;

  // Address registers drive the command address outputs directly, so both
  // reads of a vector use the same source address
  norm_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .src     (src_addr),
    .dst     (dst_addr),
    .stride  (stride),
    .cur_src (mm2s_cmd_addr),
    .cur_dst (s2mm_cmd_addr)
  );

  // Job FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      vec_cnt        <= '0;
      mm2s_cmd_valid <= 1'b0;
      s2mm_cmd_valid <= 1'b0;
      s2mm_sts_ready <= 1'b0;
      btt_q          <= '0;
      num_q          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          btt_q   <= vec_bytes;
          num_q   <= num_vec;
          error   <= 1'b0;
          vec_cnt <= '0;
          if (num_vec == '0) begin
            done <= 1'b1;
          end else if (vec_bytes == '0 || vec_bytes[2:0] != 3'd0) begin
            busy  <= 1'b1;
            state <= S_ERR;
          end else begin
            busy           <= 1'b1;
            mm2s_cmd_valid <= 1'b1;
            state          <= S_RD1_CMD;
          end
        end
        S_RD1_CMD: if (mm2s_hs) begin
          mm2s_cmd_valid <= 1'b0;
          state          <= S_RD1_WAIT;
        end
        S_RD1_WAIT: if (in_beat_last) begin
          s2mm_cmd_valid <= 1'b1;
          state          <= S_WR_CMD;
        end
        S_WR_CMD: if (s2mm_hs) begin
          s2mm_cmd_valid <= 1'b0;
          mm2s_cmd_valid <= 1'b1;
          state          <= S_RD2_CMD;
        end
        S_RD2_CMD: if (mm2s_hs) begin
          mm2s_cmd_valid <= 1'b0;
          state          <= S_RD2_WAIT;
        end
        S_RD2_WAIT: if (in_beat_last) begin
          s2mm_sts_ready <= 1'b1;
          state          <= S_WR_WAIT;
        end
        S_WR_WAIT: if (s2mm_sts_valid) begin
          s2mm_sts_ready <= 1'b0;
          if (!s2mm_sts_okay) begin
            state <= S_ERR;
          end else begin
            vec_cnt <= cnt_nxt;
            if (cnt_nxt == num_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              mm2s_cmd_valid <= 1'b1;
              state          <= S_RD1_CMD;
            end
          end
        end
        default: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm_pass_sequencer.sv
// Randomized bench for norm_pass_sequencer: an environment model answers
// commands, and a job-level reference predicts the command stream,
// event ordering and final status from the job parameters alone.
module tb_norm_pass_sequencer;
  import norm_pass_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] src_addr, dst_addr, stride;
  logic [22:0] vec_bytes;
  logic [15:0] num_vec;
  logic        busy, done, error;
  logic [15:0] vec_cnt;
  logic        mm2s_cmd_valid, mm2s_cmd_ready, s2mm_cmd_valid, s2mm_cmd_ready;
  logic [31:0] mm2s_cmd_addr, s2mm_cmd_addr;
  logic [22:0] mm2s_cmd_btt, s2mm_cmd_btt;
  logic        in_beat_last, s2mm_sts_valid, s2mm_sts_okay, s2mm_sts_ready;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  norm_pass_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .stride(stride),
    .vec_bytes(vec_bytes), .num_vec(num_vec),
    .busy(busy), .done(done), .error(error), .vec_cnt(vec_cnt),
    .mm2s_cmd_valid(mm2s_cmd_valid), .mm2s_cmd_ready(mm2s_cmd_ready),
    .mm2s_cmd_addr(mm2s_cmd_addr), .mm2s_cmd_btt(mm2s_cmd_btt),
    .s2mm_cmd_valid(s2mm_cmd_valid), .s2mm_cmd_ready(s2mm_cmd_ready),
    .s2mm_cmd_addr(s2mm_cmd_addr), .s2mm_cmd_btt(s2mm_cmd_btt),
    .in_beat_last(in_beat_last), .s2mm_sts_valid(s2mm_sts_valid),
    .s2mm_sts_okay(s2mm_sts_okay), .s2mm_sts_ready(s2mm_sts_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; mm2s_cmd_ready = 0; s2mm_cmd_ready = 0;
    in_beat_last = 0; s2mm_sts_valid = 0; s2mm_sts_okay = 0;
  endtask

  // Runs one job from the current negedge. err_vec: 0-based vector whose
  // write status is bad (-1 for none). bp: stall the first read command 5
  // cycles. rst_rd2: pulse reset while the first vector's pass 2 streams.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] st,
                         input logic [22:0] vb, input logic [15:0] n, input int err_vec,
                         input bit bp, input bit rst_rd2, input string tag);
    dm_cmd_t     rd_q[$], wr_q[$], c, prev_m;
    int          ev[$], exp_ev[$];
    int          rd_pend = 0, beat_dly = 0, sts_dly = -1, nrd = 0, nsts = 0;
    int          ndone = 0, hold_viol = 0, post = 0, bp_left, nv, bad;
    bit          prev_pend_m = 0, chk_sts = 0, sts_ok = 0, chk_last1 = 0;
    bit          fin = 0, aborted = 0, legal, err_in;
    logic [31:0] ea;

    legal   = (vb != 0) && (vb[2:0] == 3'd0);
    err_in  = (err_vec >= 0) && (err_vec < int'(n));
    bp_left = bp ? 5 : 0;

    idle_inputs();
    start = 1; src_addr = s; dst_addr = d; stride = st; vec_bytes = vb; num_vec = n;
    @(negedge clk);
    start = 0;
    chk({tag, ":start_err_clr"}, error, 0);
    chk({tag, ":start_cnt"}, vec_cnt, 0);
    if (n == 0) begin
      chk({tag, ":n0_done"}, {done, busy, mm2s_cmd_valid}, 3'b100);
    end else begin
      chk({tag, ":start_busy"}, busy, 1);
      chk({tag, ":start_mm2s_v"}, mm2s_cmd_valid, legal);
    end

    for (int cyc = 0; cyc < 3000 && post < 8; cyc++) begin
      // observe outputs settled since the last rising edge
      if (done) ndone++;
      if (chk_sts) begin
        if (!sts_ok) chk({tag, ":sts_bad_busy"}, busy, 1);
        else if (nsts == int'(n))
          chk({tag, ":last_done"}, {done, busy, vec_cnt}, {1'b1, 1'b0, n});
        else
          chk({tag, ":next_rd"}, {mm2s_cmd_valid, vec_cnt}, {1'b1, 16'(nsts)});
        chk_sts = 0;
      end
      if (chk_last1) begin
        chk({tag, ":last1_to_wr"}, s2mm_cmd_valid, 1);
        chk_last1 = 0;
      end
      if (prev_pend_m && (!mm2s_cmd_valid || mm2s_cmd_addr != prev_m.addr ||
                          mm2s_cmd_btt != prev_m.btt)) hold_viol++;
      if (fin) post++;
      else fin = !busy;

      if (rst_rd2 && rd_pend != 0 && nrd == 2) begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        chk({tag, ":rst_flags"}, {busy, done, error, mm2s_cmd_valid, s2mm_cmd_valid,
                                  s2mm_sts_ready}, 0);
        chk({tag, ":rst_cnt"}, vec_cnt, 0);
        rst = 0;
        aborted = 1;
        fin = 1;
        break;
      end

      // drive responses for the coming edge
      start = 0;
      if (busy && !fin && $urandom_range(0, 9) == 0) begin
        start = 1; src_addr = $urandom; dst_addr = $urandom; stride = $urandom;
        num_vec = 16'($urandom); vec_bytes = 23'($urandom);
      end
      if (bp_left > 0 && mm2s_cmd_valid) begin
        mm2s_cmd_ready = 0;
        bp_left--;
      end else mm2s_cmd_ready = ($urandom_range(0, 3) != 0);
      s2mm_cmd_ready = ($urandom_range(0, 2) != 0);

      in_beat_last = 0;
      if (rd_pend != 0) begin
        if (beat_dly == 0) begin
          in_beat_last = 1;
          rd_pend = 0;
          ev.push_back(2);
          chk_last1 = (nrd % 2 == 1);
        end else beat_dly--;
      end else in_beat_last = ($urandom_range(0, 9) == 0);

      s2mm_sts_valid = 0;
      s2mm_sts_okay  = 0;
      if (s2mm_sts_ready) begin
        if (sts_dly < 0) sts_dly = $urandom_range(0, 3);
        if (sts_dly == 0) begin
          s2mm_sts_valid = 1;
          s2mm_sts_okay  = (nsts != err_vec);
          sts_ok  = s2mm_sts_okay;
          chk_sts = 1;
          ev.push_back(4);
          nsts++;
          sts_dly = -1;
        end else sts_dly--;
      end else if ($urandom_range(0, 15) == 0) begin
        s2mm_sts_valid = 1;
        s2mm_sts_okay  = 1'($urandom);
      end

      c.addr = mm2s_cmd_addr;
      c.btt  = mm2s_cmd_btt;
      if (mm2s_cmd_valid && mm2s_cmd_ready) begin
        rd_q.push_back(c);
        ev.push_back(1);
        nrd++;
        rd_pend  = 1;
        beat_dly = $urandom_range(0, 4);
        prev_pend_m = 0;
      end else begin
        prev_pend_m = mm2s_cmd_valid;
        prev_m = c;
      end
      if (s2mm_cmd_valid && s2mm_cmd_ready) begin
        c.addr = s2mm_cmd_addr;
        c.btt  = s2mm_cmd_btt;
        wr_q.push_back(c);
        ev.push_back(3);
      end
      @(negedge clk);
    end
    idle_inputs();
    chk({tag, ":terminated"}, fin, 1);

    // job-level reference
    if (n == 0 || !legal) nv = 0;
    else if (rst_rd2)     nv = 1;
    else if (err_in)      nv = err_vec + 1;
    else                  nv = n;

    chk({tag, ":rd_count"}, rd_q.size(), 2 * nv);
    chk({tag, ":wr_count"}, wr_q.size(), rst_rd2 ? 1 : nv);
    for (int i = 0; i < rd_q.size() && i < 2 * nv; i++) begin
      ea = s + st * 32'(i / 2);
      chk({tag, ":rd_cmd"}, rd_q[i], {ea, vb});
    end
    for (int i = 0; i < wr_q.size() && i < nv; i++) begin
      ea = d + st * 32'(i);
      chk({tag, ":wr_cmd"}, wr_q[i], {ea, vb});
    end

    for (int v = 0; v < nv; v++) begin
      exp_ev.push_back(1); exp_ev.push_back(2); exp_ev.push_back(3); exp_ev.push_back(1);
      if (!rst_rd2) begin exp_ev.push_back(2); exp_ev.push_back(4); end
    end
    bad = (ev.size() != exp_ev.size()) ? 1 : 0;
    for (int i = 0; i < ev.size() && i < exp_ev.size(); i++)
      if (ev[i] != exp_ev[i]) bad++;
    chk({tag, ":order"}, bad, 0);

    chk({tag, ":hold"}, hold_viol, 0);
    chk({tag, ":done_cnt"}, ndone,
        (n == 0) ? 1 : ((!legal || rst_rd2 || err_in) ? 0 : 1));
    chk({tag, ":end_err"}, error, (n != 0) && (!legal || err_in) && !aborted);
    chk({tag, ":end_busy"}, busy, 0);
    chk({tag, ":end_cnt"}, vec_cnt,
        (n == 0 || !legal || rst_rd2) ? 0 : (err_in ? err_vec : int'(n)));
  endtask

  initial begin
    logic [31:0] rs, rd, rst_v;
    logic [15:0] rn;
    int          re;

    rst = 1;
    src_addr = 0; dst_addr = 0; stride = 0; vec_bytes = 0; num_vec = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset_flags", {busy, done, error, mm2s_cmd_valid, s2mm_cmd_valid, s2mm_sts_ready}, 0);
    chk("reset_cnt", vec_cnt, 0);
    rst = 0;
    @(negedge clk);

    run_job(32'h1000, 32'h8000, 32'h200, 23'd512, 16'd3, -1, 0, 0, "normal");
    repeat (2) @(negedge clk);
    run_job(32'h2000, 32'h9000, 32'h40, 23'd64, 16'd2, -1, 1, 0, "backpressure");
    repeat (2) @(negedge clk);
    run_job(32'h3000, 32'hA000, 32'h100, 23'd256, 16'd0, -1, 0, 0, "num_vec0");
    repeat (2) @(negedge clk);
    run_job(32'h3000, 32'hA000, 32'h100, 23'd12, 16'd2, -1, 0, 0, "vb12");
    repeat (2) @(negedge clk);
    run_job(32'h3000, 32'hA000, 32'h100, 23'd0, 16'd1, -1, 0, 0, "vb0");
    repeat (2) @(negedge clk);
    run_job(32'h4000, 32'hB000, 32'h80, 23'd128, 16'd4, 1, 0, 0, "sts_err");
    repeat (2) @(negedge clk);
    run_job(32'h5000, 32'hC000, 32'h20, 23'd32, 16'd1, -1, 0, 0, "after_err");
    repeat (2) @(negedge clk);
    run_job(32'h6000, 32'hD000, 32'h100, 23'd256, 16'd3, -1, 0, 1, "rst_rd2");
    repeat (2) @(negedge clk);
    run_job(32'hFFFF_FF00, 32'hFFFF_FE00, 32'h200, 23'd8, 16'd2, -1, 0, 0, "wrap");

    for (int j = 0; j < 6; j++) begin
      repeat (2) @(negedge clk);
      rs = $urandom; rd = $urandom; rst_v = $urandom;
      rn = 16'($urandom_range(1, 4));
      re = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rn - 1)) : -1;
      run_job(rs, rd, rst_v, 23'(8 * $urandom_range(1, 64)), rn, re, 0, 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
